// File: rtl/mul_seq_pkg.sv
// Shared definitions for the multiply sequencer: data width, peripheral
// register selects and the controller state encoding.
package mul_seq_pkg;

  localparam int DATA_W = 32;

  // Peripheral register map seen through sel
  localparam logic [1:0] SEL_A   = 2'b00;
  localparam logic [1:0] SEL_B   = 2'b01;
  localparam logic [1:0] SEL_GO  = 2'b10;
  localparam logic [1:0] SEL_RES = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_B,
    ST_WR_GO,
    ST_POLL,
    ST_RD_RES,
    ST_RESP
  } state_t;

endpackage

// File: rtl/bus_access.sv
// Single-access bus engine for the multiply sequencer.
// The controller presents one access as a one-cycle req pulse plus a
// descriptor (write/sel/wdata) that it holds until done. This block turns
// the pulse into the matching strobe, waits out the peripheral busy signal
// and flags completion, at which point rd_data carries the sampled rdata.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   req, req_write        start an access (pulse), direction
//   req_sel, req_wdata    register select and write data, held by the caller
//   done                  access completes this cycle (busy low after strobe)
//   rd_data               read data, valid while done is high
//   wstrb, rstrb          peripheral strobes, one cycle each
//   sel, wdata            peripheral select / write data
//   rdata, wbusy, rbusy   peripheral read data and busy flags
module bus_access
  import mul_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              req_write,
  input  logic [1:0]        req_sel,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              wstrb,
  output logic              rstrb,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              wbusy,
  input  logic              rbusy
);

  logic waiting;
  logic wr_q;

  // A request arriving while an access is still open is ignored, so a strobe
  // can never overlap an unfinished access.
  assign wstrb   = req & req_write & ~waiting;
  assign rstrb   = req & ~req_write & ~waiting;
  assign sel     = req_sel;
  assign wdata   = req_wdata;
  assign done    = waiting & ~(wr_q ? wbusy : rbusy);
  assign rd_data = rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waiting <= 1'b0;
      wr_q    <= 1'b0;
    end else if (req && !waiting) begin
      waiting <= 1'b1;
      wr_q    <= req_write;
    end else if (done) begin
      waiting <= 1'b0;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multiply sequencer: accepts an operand pair, drives it into a register-mapped
// multiplier peripheral (write A, write B, start, poll status, read result)
// and returns the low 32 bits of the product, or an error if the status
// never clears within POLL_LIMIT polls.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_a/b   command handshake and operands
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_err             product (low 32 bits), poll timeout flag
//   wstrb, rstrb, sel, wdata      peripheral access outputs
//   rdata, wbusy, rbusy           peripheral read data and busy flags
//
// state     | meaning
// ST_IDLE   | cmd_ready high, waiting for a command
// ST_WR_A   | writing operand A (sel 00)
// ST_WR_B   | writing operand B (sel 01)
// ST_WR_GO  | writing 1 to start/status (sel 10)
// ST_POLL   | reading status (sel 10) until bit 0 clears or limit hit
// ST_RD_RES | reading result (sel 11)
// ST_RESP   | rsp_valid high until rsp_ready
module mul_sequencer
  import mul_seq_pkg::*;
#(
  parameter int POLL_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              wstrb,
  output logic              rstrb,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              wbusy,
  input  logic              rbusy
);

  localparam int PCNT_W = $clog2(POLL_LIMIT + 1);

  state_t              state;
  logic [DATA_W-1:0]   b_q;
  logic [PCNT_W-1:0]   poll_cnt;
  logic                req;
  logic                req_write;
  logic [1:0]          req_sel;
  logic [DATA_W-1:0]   req_wdata;
  logic                done;
  logic [DATA_W-1:0]   rd_data;

  bus_access u_bus (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_write (req_write),
    .req_sel   (req_sel),
    .req_wdata (req_wdata),
    .done      (done),
    .rd_data   (rd_data),
    .wstrb     (wstrb),
    .rstrb     (rstrb),
    .sel       (sel),
    .wdata     (wdata),
    .rdata     (rdata),
    .wbusy     (wbusy),
    .rbusy     (rbusy)
  );

  // Operand A is latched straight into the write-data register at acceptance
  // so the first strobe goes out in the very next cycle; only B needs its own
  // holding register. Each access request is issued on the edge where the
  // previous one completes, giving back-to-back two-cycle accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      b_q       <= '0;
      poll_cnt  <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      req       <= 1'b0;
      req_write <= 1'b0;
      req_sel   <= SEL_A;
      req_wdata <= '0;
    end else begin
      req <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            b_q       <= cmd_b;
            cmd_ready <= 1'b0;
            req       <= 1'b1;
            req_write <= 1'b1;
            req_sel   <= SEL_A;
            req_wdata <= cmd_a;
            state     <= ST_WR_A;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ST_WR_A: begin
          if (done) begin
            req       <= 1'b1;
            req_sel   <= SEL_B;
            req_wdata <= b_q;
            state     <= ST_WR_B;
          end
        end
        ST_WR_B: begin
          if (done) begin
            req       <= 1'b1;
            req_sel   <= SEL_GO;
            req_wdata <= DATA_W'(1);
            state     <= ST_WR_GO;
          end
        end
        ST_WR_GO: begin
          if (done) begin
            req       <= 1'b1;
            req_write <= 1'b0;
            req_sel   <= SEL_GO;
            poll_cnt  <= '0;
            state     <= ST_POLL;
          end
        end
        ST_POLL: begin
          if (done) begin
            if (!rd_data[0]) begin
              poll_cnt <= '0;
              req      <= 1'b1;
              req_sel  <= SEL_RES;
              state    <= ST_RD_RES;
            end else if (poll_cnt == PCNT_W'(POLL_LIMIT - 1)) begin
              poll_cnt  <= '0;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              state     <= ST_RESP;
            end else begin
              poll_cnt <= poll_cnt + PCNT_W'(1);
              req      <= 1'b1;
            end
          end
        end
        ST_RD_RES: begin
          if (done) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= rd_data;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer with a register-mapped multiplier model.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        wstrb;
  logic        rstrb;
  logic [1:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        wbusy = 1'b0;
  logic        rbusy = 1'b0;

  mul_sequencer #(.POLL_LIMIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .wstrb     (wstrb),
    .rstrb     (rstrb),
    .sel       (sel),
    .wdata     (wdata),
    .rdata     (rdata),
    .wbusy     (wbusy),
    .rbusy     (rbusy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_err    = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- peripheral model ----------------
  logic [31:0] pa = '0;
  logic [31:0] pb = '0;
  int  wbusy_len = 0, rbusy_len = 0;
  int  wleft = 0, rleft = 0;
  int  poll_idx = 0;
  int  ones_n = 0;
  bit  stuck = 1'b0;

  // Busy for a cycle is decided at that cycle's falling edge, so the DUT sees
  // it at the following rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      wleft = 0; rleft = 0; wbusy = 1'b0; rbusy = 1'b0; poll_idx = 0;
    end else begin
      if (wstrb) begin
        case (sel)
          2'b00:   pa = wdata;
          2'b01:   pb = wdata;
          2'b10:   poll_idx = 0;
          default: ;
        endcase
        wleft = wbusy_len;
        wbusy = 1'b0;
      end else begin
        wbusy = (wleft != 0);
        if (wleft != 0) wleft--;
      end
      if (rstrb) begin
        if (sel == 2'b10) poll_idx++;
        rleft = rbusy_len;
        rbusy = 1'b0;
      end else begin
        rbusy = (rleft != 0);
        if (rleft != 0) rleft--;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (sel == 2'b11)      rdata = pa * pb;
    else if (sel == 2'b10) rdata = {31'd0, (stuck || (poll_idx <= ones_n))};
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int n_poll = 0, n_res = 0;
  bit acc_open = 0, acc_wr = 0, acc_ok = 0, prev_strb = 0, prev_rv = 0;
  logic [1:0]  acc_sel;
  logic [31:0] acc_wdata;
  int first_cyc = 0;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      acc_open = 0; prev_strb = 0; prev_rv = 0;
    end else begin
      if (wstrb || rstrb) begin
        check("strobe_shape", {(wstrb && rstrb), prev_strb, acc_open}, 3'b000);
        acc_open  = 1;
        acc_wr    = wstrb;
        acc_sel   = sel;
        acc_wdata = wdata;
        acc_ok    = 1;
        if (wstrb && sel == 2'b10) check("go_wdata", wdata, 32'd1);
        if (rstrb && sel == 2'b10) n_poll++;
        if (rstrb && sel == 2'b11) n_res++;
      end else if (acc_open) begin
        if (sel !== acc_sel || wdata !== acc_wdata) acc_ok = 0;
        if (!(acc_wr ? wbusy : rbusy)) begin
          check("bus_stable", acc_ok, 1'b1);
          acc_open = 0;
        end
      end
      prev_strb = wstrb || rstrb;
      if (rsp_valid && !prev_rv) first_cyc = cyc;
      prev_rv = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", (sb_q.size() != 0), 1'b1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check("rsp_data", rsp_data, mon_e.data);
          check("rsp_err", rsp_err, mon_e.err);
          check("rsp_latency", first_cyc - mon_e.acc, mon_e.lat);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [70:0] outs();
    return {cmd_ready, rsp_valid, rsp_data, rsp_err, wstrb, rstrb, sel, wdata};
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ed, input logic ee, input int lat,
                      input bit hold);
    int guard = 0;
    exp_t e;
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
    n_poll = 0;
    n_res  = 0;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    e.data = ed; e.err = ee; e.lat = lat; e.acc = cyc;
    sb_q.push_back(e);
    @(negedge clk);
    // Operands change after acceptance; the DUT must keep the latched ones.
    cmd_a = ~a;
    cmd_b = b + 32'd3;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int polls, input int res);
    int guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("rsp_arrived", sb_q.size(), 0);
    check("poll_count", n_poll, polls);
    check("res_reads", n_res, res);
  endtask

  initial begin
    int guard;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check("reset_outputs", outs(), 71'd0);
    repeat (2) @(negedge clk);
    check("ready_low_in_reset", cmd_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1'b1);

    send(32'd7, 32'd6, 32'd42, 1'b0, 11, 0);
    wait_done(1, 1);

    send(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 11, 0);
    wait_done(1, 1);

    wbusy_len = 3;
    send(32'd123, 32'd1000, 32'd123000, 1'b0, 20, 0);
    wait_done(1, 1);
    wbusy_len = 0;

    rbusy_len = 1;
    send(32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 1'b0, 13, 0);
    wait_done(1, 1);
    rbusy_len = 0;

    ones_n = 2;
    send(32'd5, 32'd5, 32'd25, 1'b0, 15, 0);
    wait_done(3, 1);
    ones_n = 0;

    stuck = 1'b1;
    send(32'h1234, 32'h10, 32'd0, 1'b1, 15, 0);
    wait_done(4, 0);
    stuck = 1'b0;

    // Response back-pressure with a new command held on the input
    rsp_ready = 1'b0;
    send(32'd9, 32'd9, 32'd81, 1'b0, 11, 1);
    guard = 0;
    while (!rsp_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("rsp_seen", rsp_valid, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("rsp_hold", {rsp_valid, rsp_err, rsp_data, cmd_ready, wstrb, rstrb},
            {1'b1, 1'b0, 32'd81, 1'b0, 1'b0, 1'b0});
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_done(1, 1);

    // Reset while polling
    stuck = 1'b1;
    send(32'd11, 32'd13, 32'd0, 1'b1, 15, 0);
    guard = 0;
    while (!(rstrb && sel == 2'b10) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("poll_reached", {rstrb, sel}, 3'b110);
    rst_n = 1'b0;
    #1 check("reset_mid_poll", outs(), 71'd0);
    sb_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("quiet_in_reset", {cmd_ready, wstrb, rstrb}, 3'b000);
    end
    stuck = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {cmd_ready, wstrb, rstrb}, 3'b100);
    send(32'd3, 32'd5, 32'd15, 1'b0, 11, 0);
    wait_done(1, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
